// File: rtl/bypass_network_pkg.sv
// Shared types and constants for the operand bypass network: register and
// word widths, the hardwired-zero register index, and the writeback-pair and
// history-entry layouts used by the top level and the stall-shadow history.
package bypass_network_pkg;

  localparam int XLEN   = 32;
  localparam int RIDX   = 5;
  localparam int WPORTS = 2;

  typedef logic [RIDX-1:0] reg_idx_t;
  typedef logic [XLEN-1:0] word_t;

  localparam reg_idx_t REG_ZERO = '0;

  // One register write: destination index (REG_ZERO means no write) and value.
  typedef struct packed {
    reg_idx_t tgt;
    word_t    data;
  } wb_pair_t;

  // Every write port of one retired writeback cycle.
  typedef wb_pair_t [WPORTS-1:0] hist_entry_t;

  // A write forwards to a read only if it targets a real register and the
  // indices agree; r0 never forwards.
  function automatic logic idx_match(input reg_idx_t wr, input reg_idx_t rd);
    return (wr != REG_ZERO) && (wr == rd);
  endfunction

endpackage

// File: rtl/bypass_hist.sv
// Stall-shadow history: a HIST-deep record of writebacks that retired while
// the consumer was stalled. Its rf_data was sampled before those writes, so
// they must stay visible until it issues. Shifts on a stalled advance, clears
// on a normal advance, holds on halt. Provides one lookup per source.
module bypass_hist
  import bypass_network_pkg::*;
#(
  parameter int HIST = 2,
  parameter int NSRC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  input  logic               shift,
  input  hist_entry_t        wb_entry,
  input  logic [NSRC*RIDX-1:0] look_idx,
  output logic [NSRC-1:0]      look_hit,
  output logic [NSRC*XLEN-1:0] look_data
);

  hist_entry_t entries [HIST];

  // Shift in the writeback while stalled, drop everything once the consumer leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the history is a few flops rather than a RAM, so every slot is
      // reset; a slot whose targets are all REG_ZERO is simply empty.
      for (int k = 0; k < HIST; k++) begin
        entries[k] <= '0;
      end
    end else if (advance) begin
      if (shift) begin
        // NOTE: non-blocking assignment makes every slot take its neighbour's
        // pre-edge value; blocking would ripple entry 0 down the whole chain.
        entries[0] <= wb_entry;
        for (int k = 1; k < HIST; k++) begin
          entries[k] <= entries[k-1];
        end
      end else begin
        for (int k = 0; k < HIST; k++) begin
          entries[k] <= '0;
        end
      end
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_look
    reg_idx_t idx;
    logic     hit;
    word_t    data;

    assign idx = look_idx[i*RIDX +: RIDX];

    // Newest-to-oldest, lowest port first: scan from lowest priority upward so
    // the last match written is the highest-priority one.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int k = HIST - 1; k >= 0; k--) begin
        for (int p = WPORTS - 1; p >= 0; p--) begin
          if (idx_match(entries[k][p].tgt, idx)) begin
            hit  = 1'b1;
            data = entries[k][p].data;
          end
        end
      end
    end

    assign look_hit[i]                = hit;
    assign look_data[i*XLEN +: XLEN] = data;
  end

endmodule

// File: rtl/bypass_network.sv
// Operand bypass and load-use hazard unit. Resolves each source operand from
// the youngest matching producer stage, then the stall-shadow history, then
// the register-file value captured at decode. Raises a combinational stall
// when a source depends on a load whose data is not yet available.
// Data width, index width and write ports per stage come from the package.
module bypass_network
  import bypass_network_pkg::*;
#(
  parameter int NSRC        = 2,
  parameter int STAGES      = 3,
  parameter int LOAD_STAGES = 2,
  parameter int HIST        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        advance,
  input  logic                        cons_valid,
  input  logic [NSRC*RIDX-1:0]        src_idx,
  input  logic [NSRC*XLEN-1:0]        rf_data,
  input  logic [STAGES*WPORTS*RIDX-1:0] stg_tgt,
  input  logic [STAGES*WPORTS*XLEN-1:0] stg_data,
  input  logic [STAGES-1:0]           stg_valid,
  input  logic [STAGES-1:0]           stg_is_load,
  output logic [NSRC*XLEN-1:0]        operand,
  output logic                        stall,
  output logic [NSRC-1:0]             fwd_hit
);

  // The history must cover every cycle a consumer can be held by a load.
  if (HIST < LOAD_STAGES) begin : g_bad_hist
    $error("bypass_network: HIST (%0d) must be >= LOAD_STAGES (%0d)", HIST, LOAD_STAGES);
  end
  if (LOAD_STAGES > STAGES || LOAD_STAGES < 1) begin : g_bad_load
    $error("bypass_network: LOAD_STAGES (%0d) must be in 1..STAGES (%0d)", LOAD_STAGES, STAGES);
  end

  // Load flags of stages whose results are already available play no part.
  if (LOAD_STAGES < STAGES) begin : g_unused_load
    logic unused_load;
    assign unused_load = ^stg_is_load[STAGES-1:LOAD_STAGES];
  end

  localparam int WB = STAGES - 1;

  hist_entry_t         wb_entry;
  logic [NSRC-1:0]      hist_hit;
  logic [NSRC*XLEN-1:0] hist_data;
  logic [NSRC-1:0]      src_hazard;

  // Writeback stage packed as a history entry; a bubble writes nothing.
  always_comb begin
    for (int p = 0; p < WPORTS; p++) begin
      wb_entry[p].tgt  = stg_valid[WB] ? stg_tgt[(WB*WPORTS + p)*RIDX +: RIDX] : REG_ZERO;
      wb_entry[p].data = stg_data[(WB*WPORTS + p)*XLEN +: XLEN];
    end
  end

  bypass_hist #(
    .HIST (HIST),
    .NSRC (NSRC)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .shift     (stall),
    .wb_entry  (wb_entry),
    .look_idx  (src_idx),
    .look_hit  (hist_hit),
    .look_data (hist_data)
  );

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    reg_idx_t idx;
    word_t    res_data;
    logic     res_hit;
    logic     hazard;

    assign idx = src_idx[i*RIDX +: RIDX];

    // Priority mux: stages youngest-first and ports low-first beat the
    // history, which beats rf_data. Scanned lowest priority first so the
    // winning match is the last one assigned.
    always_comb begin
      // NOTE: both outputs get a default before any branch so every path
      // assigns them; a missing default here would infer a latch.
      res_data = rf_data[i*XLEN +: XLEN];
      res_hit  = 1'b0;
      if (idx != REG_ZERO) begin
        if (hist_hit[i]) begin
          res_data = hist_data[i*XLEN +: XLEN];
          res_hit  = 1'b1;
        end
        for (int s = STAGES - 1; s >= 0; s--) begin
          for (int p = WPORTS - 1; p >= 0; p--) begin
            if (stg_valid[s] && idx_match(stg_tgt[(s*WPORTS + p)*RIDX +: RIDX], idx)) begin
              res_data = stg_data[(s*WPORTS + p)*XLEN +: XLEN];
              res_hit  = 1'b1;
            end
          end
        end
      end
    end

    // Load-use compare: this source reads a register an in-flight load writes.
    always_comb begin
      hazard = 1'b0;
      for (int s = 0; s < LOAD_STAGES; s++) begin
        for (int p = 0; p < WPORTS; p++) begin
          if (stg_valid[s] && stg_is_load[s] &&
              idx_match(stg_tgt[(s*WPORTS + p)*RIDX +: RIDX], idx)) begin
            hazard = 1'b1;
          end
        end
      end
    end

    assign operand[i*XLEN +: XLEN] = res_data;
    assign fwd_hit[i]              = res_hit;
    assign src_hazard[i]           = hazard;
  end

  // Only a real consumer stalls, and never while reset is asserted.
  assign stall = !rst && cons_valid && (|src_hazard);

endmodule

// File: tb/tb_bypass_network.sv
// Self-checking bench for bypass_network: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based behavioural model of forwarding, stall and stall-shadow history.
module tb_bypass_network;
  import bypass_network_pkg::*;

  localparam int NSRC        = 2;
  localparam int STAGES      = 3;
  localparam int LOAD_STAGES = 2;
  localparam int HIST        = 2;

  logic                          clk;
  logic                          rst;
  logic                          advance;
  logic                          cons_valid;
  logic [NSRC*RIDX-1:0]          src_idx;
  logic [NSRC*XLEN-1:0]          rf_data;
  logic [STAGES*WPORTS*RIDX-1:0] stg_tgt;
  logic [STAGES*WPORTS*XLEN-1:0] stg_data;
  logic [STAGES-1:0]             stg_valid;
  logic [STAGES-1:0]             stg_is_load;
  logic [NSRC*XLEN-1:0]          operand;
  logic                          stall;
  logic [NSRC-1:0]               fwd_hit;

  bypass_network #(
    .NSRC        (NSRC),
    .STAGES      (STAGES),
    .LOAD_STAGES (LOAD_STAGES),
    .HIST        (HIST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .advance     (advance),
    .cons_valid  (cons_valid),
    .src_idx     (src_idx),
    .rf_data     (rf_data),
    .stg_tgt     (stg_tgt),
    .stg_data    (stg_data),
    .stg_valid   (stg_valid),
    .stg_is_load (stg_is_load),
    .operand     (operand),
    .stall       (stall),
    .fwd_hit     (fwd_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Retired writebacks seen during a stall, newest at the front.
  typedef struct packed {
    logic [WPORTS*RIDX-1:0] tgt;
    logic [WPORTS*XLEN-1:0] data;
  } m_ent_t;
  m_ent_t hq[$];

  // Returns {hit, data} for source i from the current inputs and model history.
  function automatic logic [XLEN:0] model_op(input int i);
    logic [RIDX-1:0] s;
    logic [XLEN-1:0] rf;
    s  = src_idx[i*RIDX +: RIDX];
    rf = rf_data[i*XLEN +: XLEN];
    if (s == 0) return {1'b0, rf};
    for (int st = 0; st < STAGES; st++)
      for (int p = 0; p < WPORTS; p++)
        if (stg_valid[st] && stg_tgt[(st*WPORTS+p)*RIDX +: RIDX] == s)
          return {1'b1, stg_data[(st*WPORTS+p)*XLEN +: XLEN]};
    foreach (hq[h])
      for (int p = 0; p < WPORTS; p++)
        if (hq[h].tgt[p*RIDX +: RIDX] == s)
          return {1'b1, hq[h].data[p*XLEN +: XLEN]};
    return {1'b0, rf};
  endfunction

  function automatic logic model_stall();
    logic [RIDX-1:0] t;
    if (rst || !cons_valid) return 1'b0;
    for (int st = 0; st < LOAD_STAGES; st++) begin
      if (!(stg_valid[st] && stg_is_load[st])) continue;
      for (int p = 0; p < WPORTS; p++) begin
        t = stg_tgt[(st*WPORTS+p)*RIDX +: RIDX];
        if (t == 0) continue;
        for (int i = 0; i < NSRC; i++)
          if (src_idx[i*RIDX +: RIDX] == t) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Model history update at the clock edge, from the pre-edge inputs.
  always @(posedge clk) begin : model_upd
    logic   st;
    m_ent_t e;
    st = model_stall();
    if (rst) begin
      hq.delete();
    end else if (advance) begin
      if (st) begin
        e.tgt  = stg_valid[STAGES-1] ? stg_tgt[(STAGES-1)*WPORTS*RIDX +: WPORTS*RIDX] : '0;
        e.data = stg_data[(STAGES-1)*WPORTS*XLEN +: WPORTS*XLEN];
        hq.push_front(e);
        if (hq.size() > HIST) void'(hq.pop_back());
      end else begin
        hq.delete();
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    logic [XLEN:0] exp;
    if (cmp_en) begin
      for (int i = 0; i < NSRC; i++) begin
        exp = model_op(i);
        check($sformatf("model_operand%0d", i), 64'(operand[i*XLEN +: XLEN]), 64'(exp[XLEN-1:0]));
        check($sformatf("model_fwd_hit%0d", i), 64'(fwd_hit[i]), 64'(exp[XLEN]));
      end
      check("model_stall", 64'(stall), 64'(model_stall()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rst = 1'b0; advance = 1'b1; cons_valid = 1'b0;
    src_idx = '0; rf_data = '0; stg_tgt = '0; stg_data = '0;
    stg_valid = '0; stg_is_load = '0;
  endtask

  task automatic set_stage(input int s, input int p, input logic [RIDX-1:0] t, input logic [XLEN-1:0] d);
    stg_tgt[(s*WPORTS+p)*RIDX +: RIDX]  = t;
    stg_data[(s*WPORTS+p)*XLEN +: XLEN] = d;
  endtask

  task automatic set_src(input int i, input logic [RIDX-1:0] t, input logic [XLEN-1:0] d);
    src_idx[i*RIDX +: RIDX] = t;
    rf_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] op(input int i);
    return 64'(operand[i*XLEN +: XLEN]);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [XLEN:0] mexp;

    // Reset with a load-use hazard present: stall must stay low.
    idle();
    rst = 1'b1; cons_valid = 1'b1;
    set_stage(0, 0, 5'd5, 32'h55); stg_valid[0] = 1'b1; stg_is_load[0] = 1'b1;
    set_src(1, 5'd5, 32'h22);
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    next();
    cmp_en = 1'b1;

    // Plain read from the register file.
    idle(); cons_valid = 1'b1;
    set_src(0, 5'd3, 32'h11); set_src(1, 5'd4, 32'h22);
    @(negedge clk);
    check("plain_op0", op(0), 64'h11);
    check("plain_op1", op(1), 64'h22);
    check("plain_fwd", 64'(fwd_hit), 64'd0);
    check("plain_stall", 64'(stall), 64'd0);

    // Priority: youngest stage beats writeback; bubble falls through.
    next(); idle();
    set_stage(0, 1, 5'd3, 32'hAA); stg_valid[0] = 1'b1;
    set_stage(2, 0, 5'd3, 32'hBB); stg_valid[2] = 1'b1;
    set_src(0, 5'd3, 32'h11);
    @(negedge clk);
    check("prio_stage0", op(0), 64'hAA);
    check("prio_fwd0", 64'(fwd_hit[0]), 64'd1);
    next(); stg_valid[0] = 1'b0;
    @(negedge clk);
    check("prio_stage2", op(0), 64'hBB);

    // r0 never forwards.
    next(); idle();
    set_stage(0, 0, 5'd0, 32'hFF); stg_valid[0] = 1'b1;
    set_src(0, 5'd0, 32'h33);
    @(negedge clk);
    check("r0_op0", op(0), 64'h33);
    check("r0_fwd0", 64'(fwd_hit[0]), 64'd0);

    // Load-use stall, bubble consumer, and non-load forward.
    next(); idle();
    set_stage(0, 0, 5'd5, 32'h55); stg_valid[0] = 1'b1; stg_is_load[0] = 1'b1;
    set_src(1, 5'd5, 32'h22); cons_valid = 1'b1;
    @(negedge clk);
    check("lu_stall", 64'(stall), 64'd1);
    next(); cons_valid = 1'b0;
    @(negedge clk);
    check("lu_bubble", 64'(stall), 64'd0);
    next(); cons_valid = 1'b1; stg_is_load[0] = 1'b0;
    @(negedge clk);
    check("lu_noload_stall", 64'(stall), 64'd0);
    check("lu_noload_op1", op(1), 64'h55);
    check("lu_noload_fwd1", 64'(fwd_hit[1]), 64'd1);

    // Stall shadow: two stalled cycles retire r7 twice; the newest survives.
    next(); idle(); cons_valid = 1'b1;
    set_src(0, 5'd7, 32'h1); set_src(1, 5'd9, 32'h0);
    set_stage(0, 0, 5'd9, 32'h0); stg_valid[0] = 1'b1; stg_is_load[0] = 1'b1;
    set_stage(2, 0, 5'd7, 32'h1234); stg_valid[2] = 1'b1;
    @(negedge clk);
    check("shadow_stall1", 64'(stall), 64'd1);
    next();
    stg_valid[0] = 1'b0; stg_is_load[0] = 1'b0; set_stage(0, 0, 5'd0, 32'h0);
    set_stage(1, 0, 5'd9, 32'h0); stg_valid[1] = 1'b1; stg_is_load[1] = 1'b1;
    set_stage(2, 0, 5'd7, 32'h5678);
    @(negedge clk);
    check("shadow_stall2", 64'(stall), 64'd1);
    next(); idle(); cons_valid = 1'b1;
    set_src(0, 5'd7, 32'h1); set_src(1, 5'd9, 32'h0);
    @(negedge clk);
    mexp = model_op(0);
    check("shadow_model", 64'(mexp[XLEN-1:0]), 64'h5678);
    check("shadow_op0", op(0), 64'h5678);
    check("shadow_fwd0", 64'(fwd_hit[0]), 64'd1);
    check("shadow_stall_drop", 64'(stall), 64'd0);
    next();
    @(negedge clk);
    check("shadow_cleared_op0", op(0), 64'h1);
    check("shadow_cleared_fwd0", 64'(fwd_hit[0]), 64'd0);

    // Halt during a stall holds history; reset mid-stall clears it.
    next(); idle(); cons_valid = 1'b1;
    set_src(0, 5'd7, 32'h1); set_src(1, 5'd9, 32'h0);
    set_stage(0, 0, 5'd9, 32'h0); stg_valid[0] = 1'b1; stg_is_load[0] = 1'b1;
    set_stage(2, 0, 5'd7, 32'h1234); stg_valid[2] = 1'b1;
    @(negedge clk);
    check("halt_setup_stall", 64'(stall), 64'd1);
    next(); advance = 1'b0; set_stage(2, 0, 5'd8, 32'h9999);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("halt_op0_c%0d", c), op(0), 64'h1234);
      check($sformatf("halt_stall_c%0d", c), 64'(stall), 64'd1);
      next();
    end
    advance = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_stall", 64'(stall), 64'd0);
    check("rst_mid_op0", op(0), 64'h1234);
    next(); rst = 1'b0;
    @(negedge clk);
    check("rst_cleared_op0", op(0), 64'h1);
    check("rst_cleared_fwd0", 64'(fwd_hit[0]), 64'd0);

    // Randomized traffic; small register range to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      next();
      rst        = ($urandom_range(0, 63) == 0);
      advance    = ($urandom_range(0, 9) != 0);
      cons_valid = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NSRC; i++)
        set_src(i, RIDX'($urandom_range(0, 7)), $urandom);
      for (int s = 0; s < STAGES; s++) begin
        stg_valid[s]   = ($urandom_range(0, 3) != 0);
        stg_is_load[s] = ($urandom_range(0, 3) == 0);
        for (int p = 0; p < WPORTS; p++)
          set_stage(s, p, RIDX'($urandom_range(0, 7)), $urandom);
      end
    end

    next();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bypass_network.md
Name: bypass_network

Overview:
- Parametrised operand-bypass and load-use hazard unit. It feeds the execute stage with resolved source operands.
- Generalises fixed two-source forwarding from EX/MEM/WB to STAGES producer stages, WPORTS write ports per stage, NSRC sources, and a HIST-deep stall-shadow history of retired writebacks.
- Sits between decode/regfile read and the ALU.
- Operand resolution and stall are combinational. The history buffer is the sequential state.

Parameters:
- XLEN, 32, data width.
- RIDX, 5, register index width; r0 is hardwired zero.
- NSRC, 2, source operands per instruction.
- STAGES, 3, producer stages downstream of the consumer; index 0 is youngest (EX out), STAGES-1 is writeback.
- WPORTS, 2, register writes per stage (e.g. post-increment result plus address).
- LOAD_STAGES, 2, youngest stages whose load results are not yet available.
- HIST, 2, history depth. Elaboration error if HIST < LOAD_STAGES.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- advance  in  1  pipeline advances this cycle (low = global halt; all state holds).
- cons_valid  in  1  consumer instruction is not a bubble.
- src_idx  in  NSRC*RIDX  source register indices.
- rf_data  in  NSRC*XLEN  register-file read data captured at decode.
- stg_tgt  in  STAGES*WPORTS*RIDX  destination indices; 0 = no write.
- stg_data  in  STAGES*WPORTS*XLEN  results per stage and port.
- stg_valid  in  STAGES  stage holds a non-bubble instruction.
- stg_is_load  in  STAGES  stage instruction is a load.
- operand  out  NSRC*XLEN  resolved operands.
- stall  out  1  load-use stall request.
- fwd_hit  out  NSRC  operand came from a stage or history, not rf_data.

Behaviour:
- Reset (rst=1 at posedge): all HIST entries cleared (tgt=0).
- While rst=1: stall forced to 0; operand still resolves combinationally.
- Operand resolution, 0 latency, per source i:
  - src_idx[i]==0: rf_data[i], fwd_hit[i]=0.
  - Otherwise first match wins in this order: stage 0 port 0, stage 0 port 1, …, stage STAGES-1 last port, then history newest to oldest, else rf_data[i].
  - A stage matches only if stg_valid is set and stg_tgt == src_idx.
  - Two ports of one stage writing the same register: lower port index wins.
- Stall = cons_valid AND some stage s < LOAD_STAGES with stg_valid[s] & stg_is_load[s] has a nonzero stg_tgt equal to any src_idx. Stall is combinational, same cycle.
- History update at posedge, only when advance=1 and rst=0:
  - stall=1: shift. Entry 0 <= writeback stage's {tgt,data} for every port (tgt forced to 0 if !stg_valid[STAGES-1]); entry k <= entry k-1; oldest dropped.
  - stall=0: clear all entries. The consumer leaves, so its stale rf_data is no longer needed.
- advance=0: history holds regardless of stall.
- Each history entry holds WPORTS {tgt,data} pairs. Matching order inside an entry is by port index.
- Rationale: rf_data was sampled before the stall. Writebacks retiring during the stall must stay visible until the consumer issues.
- Stall runs at most LOAD_STAGES consecutive cycles for one consumer. HIST >= LOAD_STAGES guarantees no retired write is lost.
- Simultaneous advance and rst: reset wins.

Decomposition:
- Shared package: RIDX, XLEN, REG_ZERO constant, typedef wb_pair_t {tgt,data}, typedef hist_entry_t (WPORTS x wb_pair_t).
- One sub-module, bypass_hist: the HIST-deep shift/clear register with a lookup port.
- Priority mux and stall compare stay in the top level as generate loops.

Test Plan:
- Plain read: src=(3,4), no stage matches, rf=(0x11,0x22) -> operand=(0x11,0x22), fwd_hit=00, stall=0.
- Priority: stage0 port1 tgt=3 data=0xAA and stage2 port0 tgt=3 data=0xBB, src0=3 -> operand0=0xAA. Same with stg_valid[0]=0 -> 0xBB.
- r0: src0=0 while stage0 tgt=0 data=0xFF -> operand0=rf_data0, fwd_hit0=0.
- Load-use: stage0 load tgt=5, src1=5, cons_valid=1 -> stall=1. cons_valid=0 -> stall=0. Same with non-load -> stall=0 and forwarded data.
- Stall shadow: two-cycle stall. WB retires r7=0x1234 in cycle 1 and r7=0x5678 in cycle 2 -> after stall, with no stage match on r7, operand=0x5678. History empty one cycle after stall drops.
- Halt/reset: advance=0 during stall -> history unchanged for 3 cycles. rst mid-stall -> stall=0 and history cleared next cycle.
